// File: rtl/param_demux_pkg.sv
// param_demux_pkg: shared select-width helper and FSM encoding for param_demux_deser.
package param_demux_pkg;
  localparam logic ST_FILL = 1'b0;
  localparam logic ST_LAST = 1'b1;
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/demux_fill_ctr.sv
// demux_fill_ctr: modulo-N fill counter with enable, sync clear and terminal-count flag.
// Counts N-1 down to 0 when PARAM_DEMUX_DESER_MSB_FIRST_EN is defined, else 0 up to N-1.
module demux_fill_ctr
  import param_demux_pkg::*;
#(
  parameter int N = 8,
  localparam int SW = safe_clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic          i_clr,
  output logic [SW-1:0] o_cnt,
  output logic          o_tc
);
  localparam logic [SW-1:0] TOP = SW'(N - 1);
`ifdef PARAM_DEMUX_DESER_MSB_FIRST_EN
  localparam logic [SW-1:0] START = TOP;
  localparam logic [SW-1:0] STOP = '0;
`else
  localparam logic [SW-1:0] START = '0;
  localparam logic [SW-1:0] STOP = TOP;
`endif
  logic [SW-1:0] r_cnt;
  logic [SW-1:0] w_step;
`ifdef PARAM_DEMUX_DESER_MSB_FIRST_EN
  assign w_step = (r_cnt == '0) ? TOP : r_cnt - 1'b1;
`else
  assign w_step = (r_cnt == TOP) ? '0 : r_cnt + 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_cnt <= START;
    else if (i_en) r_cnt <= w_step;
  end
  assign o_cnt = r_cnt;
  assign o_tc = (r_cnt == STOP);
endmodule

// File: rtl/param_demux_deser.sv
// param_demux_deser: 1:N demux with an auto-stepping deserializer mode.
// Define PARAM_DEMUX_DESER_MSB_FIRST_EN to fill auto-mode words from position N-1 down.
module param_demux_deser
  import param_demux_pkg::*;
#(
  parameter int N = 8,
  localparam int SW = safe_clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          d_in,
  input  logic          d_valid,
  input  logic          auto,
  input  logic [SW-1:0] s,
  output logic [N-1:0]  y,
  output logic [N-1:0]  word,
  output logic          word_valid,
  output logic [SW-1:0] ptr
);
  localparam logic ST_INIT = (N == 1) ? ST_LAST : ST_FILL;
`ifdef PARAM_DEMUX_DESER_MSB_FIRST_EN
  localparam logic [SW-1:0] PRE = SW'(1);
`else
  localparam logic [SW-1:0] PRE = SW'((N > 1) ? N - 2 : 0);
`endif
  logic          r_state, w_nstate;
  logic          w_tc, w_wr_auto, w_done, w_we;
  logic [SW-1:0] w_idx;
  logic [N-1:0]  r_y, r_word, w_y_nxt;
  logic          r_wv;
  demux_fill_ctr #(.N(N)) u_ctr (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_wr_auto),
    .i_clr (!auto),
    .o_cnt (ptr),
    .o_tc  (w_tc)
  );
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_INIT;
    else r_state <= w_nstate;
  end
  // PRE is the position one accepted bit before the terminal one
  always_comb begin
    w_nstate = !auto ? ST_INIT :
               !d_valid ? r_state :
               (r_state == ST_LAST) ? ST_INIT :
               (ptr == PRE) ? ST_LAST : ST_FILL;
  end
  always_comb begin
    w_wr_auto = auto & d_valid;
    w_done = w_wr_auto & (r_state == ST_LAST) & w_tc;
    w_idx = auto ? ptr : s;
    w_we = d_valid & (auto | ({1'b0, s} < (SW + 1)'(N)));
    w_y_nxt = r_y;
    if (w_we) w_y_nxt[w_idx] = d_in;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y <= '0;
      r_word <= '0;
      r_wv <= 1'b0;
    end else begin
      r_y <= w_y_nxt;
      r_wv <= w_done;
      if (w_done) r_word <= w_y_nxt;
    end
  end
  assign y = r_y;
  assign word = r_word;
  assign word_valid = r_wv;
endmodule

// File: tb/tb_param_demux_deser.sv
// tb_param_demux_deser: directed scoreboard bench for N=8 and N=5 instances.
module tb_param_demux_deser;
`ifdef PARAM_DEMUX_DESER_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif
  logic clk = 1'b0, rst;
  always #5 clk = ~clk;
  logic dv8, a8, d8, wv8;
  logic [2:0] s8, p8;
  logic [7:0] y8, w8, e8;
  logic dv5, a5, d5, wv5;
  logic [2:0] s5, p5;
  logic [4:0] y5, w5, e5;
  int nchk = 0, npass = 0;
  logic [7:0] q8[$];
  logic [4:0] q5[$];

  param_demux_deser #(.N(8)) u8 (
    .clk(clk), .rst(rst), .d_in(d8), .d_valid(dv8), .auto(a8), .s(s8),
    .y(y8), .word(w8), .word_valid(wv8), .ptr(p8)
  );
  param_demux_deser #(.N(5)) u5 (
    .clk(clk), .rst(rst), .d_in(d5), .d_valid(dv5), .auto(a5), .s(s5),
    .y(y5), .word(w5), .word_valid(wv5), .ptr(p5)
  );

  function automatic logic [7:0] wexp(input logic [7:0] p, input int n);
    logic [7:0] r;
    r = p;
    if (MSB) begin
      r = '0;
      for (int i = 0; i < n; i++) r[n-1-i] = p[i];
    end
    return r;
  endfunction

  function automatic logic [2:0] pos(input int k, input int n);
    return MSB ? 3'(n - 1 - k) : 3'(k);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", nm, got, exp);
  endtask

  task automatic cyc8(input logic dv, input logic a, input logic d, input logic [2:0] s);
    @(negedge clk);
    dv8 = dv; a8 = a; d8 = d; s8 = s;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc5(input logic dv, input logic a, input logic d, input logic [2:0] s);
    @(negedge clk);
    dv5 = dv; a5 = a; d5 = d; s5 = s;
    @(posedge clk);
    #1;
  endtask

  task automatic word8(input logic [7:0] p, input bit gap);
    for (int i = 0; i < 8; i++) begin
      if (gap) begin
        cyc8(1'b0, 1'b1, 1'b0, 3'd0);
        chk("gap_wv8", 32'(wv8), 32'd0);
      end
      if (i == 7) q8.push_back(wexp(p, 8));
      cyc8(1'b1, 1'b1, p[i], 3'd0);
      chk("ptr8", 32'(p8), 32'(pos((i + 1) % 8, 8)));
      chk("wv8_latency", 32'(wv8), 32'(i == 7));
    end
  endtask

  task automatic word5(input logic [4:0] p);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) q5.push_back(5'(wexp({3'b0, p}, 5)));
      cyc5(1'b1, 1'b1, p[i], 3'd0);
      chk("ptr5", 32'(p5), 32'(pos((i + 1) % 5, 5)));
      chk("wv5_latency", 32'(wv5), 32'(i == 4));
    end
  endtask

  // scoreboard monitor: every pulse must match the oldest expected word
  always @(negedge clk) begin
    if (wv8 === 1'b1) begin
      nchk++;
      if (q8.size() == 0) $display("FAIL word8_unexpected: got %0h want none", w8);
      else begin
        e8 = q8.pop_front();
        if (w8 === e8) npass++;
        else $display("FAIL word8: got %0h want %0h", w8, e8);
      end
    end
    if (wv5 === 1'b1) begin
      nchk++;
      if (q5.size() == 0) $display("FAIL word5_unexpected: got %0h want none", w5);
      else begin
        e5 = q5.pop_front();
        if (w5 === e5) npass++;
        else $display("FAIL word5: got %0h want %0h", w5, e5);
      end
    end
  end

  initial begin
    rst = 1'b1;
    dv8 = 1'b1; a8 = 1'b1; d8 = 1'b1; s8 = 3'd0;
    dv5 = 1'b1; a5 = 1'b1; d5 = 1'b1; s5 = 3'd0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_y8", 32'(y8), 32'd0);
      chk("rst_word8", 32'(w8), 32'd0);
      chk("rst_wv8", 32'(wv8), 32'd0);
      chk("rst_ptr8", 32'(p8), 32'(pos(0, 8)));
      chk("rst_y5", 32'(y5), 32'd0);
      chk("rst_ptr5", 32'(p5), 32'(pos(0, 5)));
    end
    @(negedge clk);
    rst = 1'b0; dv8 = 1'b0; a8 = 1'b0; dv5 = 1'b0; a5 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc8(1'b1, 1'b0, 1'b1, 3'(i));
      chk("man_y8", 32'(y8), (32'd1 << (i + 1)) - 32'd1);
      chk("man_ptr8", 32'(p8), 32'(pos(0, 8)));
    end
    cyc8(1'b1, 1'b0, 1'b0, 3'd3);
    chk("man_clr3_y8", 32'(y8), 32'hF7);
    word8(8'h4D, 1'b0);
    cyc8(1'b0, 1'b1, 1'b0, 3'd0);
    chk("hold_wv8", 32'(wv8), 32'd0);
    chk("hold_word8", 32'(w8), 32'(wexp(8'h4D, 8)));
    chk("hold_y8", 32'(y8), 32'(wexp(8'h4D, 8)));
    word8(8'h4D, 1'b1);
    word8(8'hFF, 1'b0);
    repeat (3) cyc8(1'b1, 1'b1, 1'b1, 3'd0);
    chk("abort_mid_ptr8", 32'(p8), 32'(pos(3, 8)));
    cyc8(1'b0, 1'b0, 1'b0, 3'd0);
    chk("abort_ptr8", 32'(p8), 32'(pos(0, 8)));
    chk("abort_wv8", 32'(wv8), 32'd0);
    word8(8'hA5, 1'b0);
    cyc8(1'b0, 1'b0, 1'b0, 3'd0);
    cyc5(1'b1, 1'b0, 1'b1, 3'd2);
    chk("man_y5", 32'(y5), 32'h04);
    cyc5(1'b1, 1'b0, 1'b1, 3'd6);
    chk("oob6_y5", 32'(y5), 32'h04);
    cyc5(1'b1, 1'b0, 1'b1, 3'd5);
    chk("oob5_y5", 32'(y5), 32'h04);
    chk("man_ptr5", 32'(p5), 32'(pos(0, 5)));
    word5(5'b10110);
    word5(5'b01001);
    cyc5(1'b0, 1'b0, 1'b0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q5_drained", 32'(q5.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
